sequence_checker: RTL and testbench

SEQUENCE_CHECKER -- requirements
Module: sequence_checker

---
 rtl/sequence_checker.sv | 132 +++++++++++++
 tb/tb_sequence_checker.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// Locks onto a fixed 8-entry repeating byte sequence and tracks matches and mismatches.
// It returns to hunting after MISS_LIMIT consecutive mismatches.
module sequence_checker #(
  parameter int unsigned MISS_LIMIT = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  output logic        locked_o,
  output logic        error_o,
  output logic [7:0]  expected_o,
  output logic [15:0] match_count_o,
  output logic [7:0]  err_count_o
);

  localparam logic [7:0] HuntByte = 8'hAF;

  typedef enum logic [0:0] {StHunt, StLocked} state_e;

  function automatic logic [7:0] seq_entry(input logic [2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd0:    v = 8'hAF;
      3'd1:    v = 8'hBC;
      3'd2:    v = 8'hE2;
      3'd3:    v = 8'h78;
      3'd4:    v = 8'h1B;
      3'd5:    v = 8'h34;
      3'd6:    v = 8'h5D;
      default: v = 8'hC6;
    endcase
    return v;
  endfunction

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  miss_q, miss_d;
  logic [15:0] match_q, match_d;
  logic [7:0]  errc_q, errc_d;
  logic        error_q, error_d;
  logic [7:0]  expected_q, expected_d;
  logic [3:0]  miss_inc;
  logic [15:0] match_inc;
  logic [7:0]  errc_inc;

  assign miss_inc  = miss_q + 4'd1;
  assign match_inc = (match_q == 16'hFFFF) ? match_q : match_q + 16'd1;
  assign errc_inc  = (errc_q == 8'hFF) ? errc_q : errc_q + 8'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    miss_d     = miss_q;
    match_d    = match_q;
    errc_d     = errc_q;
    error_d    = 1'b0;
    expected_d = expected_q;

    if (clear_i) begin
      state_d    = StHunt;
      idx_d      = 3'd0;
      miss_d     = 4'd0;
      match_d    = 16'd0;
      errc_d     = 8'd0;
      expected_d = HuntByte;
    end else if (valid_i) begin
      unique case (state_q)
        StHunt: begin
          // An unknown data bit fails the equality and is simply ignored here.
          if (data_i == HuntByte) begin
            state_d    = StLocked;
            idx_d      = 3'd1;
            match_d    = match_inc;
            expected_d = seq_entry(3'd1);
          end
        end
        StLocked: begin
          if (data_i == seq_entry(idx_q)) begin
            match_d    = match_inc;
            miss_d     = 4'd0;
            idx_d      = idx_q + 3'd1;
            expected_d = seq_entry(idx_q + 3'd1);
          end else begin
            error_d = 1'b1;
            errc_d  = errc_inc;
            if (miss_inc >= 4'(MISS_LIMIT)) begin
              state_d    = StHunt;
              idx_d      = 3'd0;
              miss_d     = 4'd0;
              expected_d = HuntByte;
            end else begin
              // Slip assumed by value only, so position keeps advancing.
              miss_d     = miss_inc;
              idx_d      = idx_q + 3'd1;
              expected_d = seq_entry(idx_q + 3'd1);
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StHunt;
      idx_q      <= 3'd0;
      miss_q     <= 4'd0;
      match_q    <= 16'd0;
      errc_q     <= 8'd0;
      error_q    <= 1'b0;
      expected_q <= HuntByte;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      miss_q     <= miss_d;
      match_q    <= match_d;
      errc_q     <= errc_d;
      error_q    <= error_d;
      expected_q <= expected_d;
    end
  end

  assign locked_o      = (state_q == StLocked);
  assign error_o       = error_q;
  assign expected_o    = expected_q;
  assign match_count_o = match_q;
  assign err_count_o   = errc_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Bench for sequence_checker: vector table, hand-written corner sequences, and
// random traffic against a behavioural model.
module tb_sequence_checker;

  localparam int unsigned Limit = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        valid;
  logic [7:0]  data;
  logic        locked;
  logic        error;
  logic [7:0]  expected;
  logic [15:0] match_count;
  logic [7:0]  err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sequence_checker #(.MISS_LIMIT(Limit)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clear_i      (clear),
    .valid_i      (valid),
    .data_i       (data),
    .locked_o     (locked),
    .error_o      (error),
    .expected_o   (expected),
    .match_count_o(match_count),
    .err_count_o  (err_count)
  );

  // Behavioural model
  byte unsigned seq_tbl [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'h1B, 8'h34, 8'h5D, 8'hC6};
  bit m_locked;
  bit m_error;
  int m_pos;
  int m_miss;
  int m_match;
  int m_errc;

  function automatic void model_reset();
    m_locked = 0; m_error = 0; m_pos = 0; m_miss = 0; m_match = 0; m_errc = 0;
  endfunction

  function automatic int model_expected();
    return m_locked ? int'(seq_tbl[m_pos]) : 'hAF;
  endfunction

  function automatic void model_step(input bit v, input bit c, input byte unsigned d);
    m_error = 0;
    if (c) begin
      model_reset();
    end else if (v) begin
      if (!m_locked) begin
        if (d == 8'hAF) begin
          m_locked = 1;
          m_pos    = 1;
          m_match  = (m_match < 65535) ? m_match + 1 : 65535;
        end
      end else if (d == seq_tbl[m_pos]) begin
        m_match = (m_match < 65535) ? m_match + 1 : 65535;
        m_pos   = (m_pos + 1) % 8;
        m_miss  = 0;
      end else begin
        m_error = 1;
        m_errc  = (m_errc < 255) ? m_errc + 1 : 255;
        m_miss  = m_miss + 1;
        if (m_miss >= int'(Limit)) begin
          m_locked = 0;
          m_pos    = 0;
          m_miss   = 0;
        end else begin
          m_pos = (m_pos + 1) % 8;
        end
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_all(input string tag, input bit l, input bit e, input logic [7:0] x,
                           input int mc, input int ec);
    chk({tag, ".locked"}, 32'(locked), 32'(l));
    chk({tag, ".error"}, 32'(error), 32'(e));
    chk({tag, ".expected"}, 32'(expected), 32'(x));
    chk({tag, ".match_count"}, 32'(match_count), mc);
    chk({tag, ".err_count"}, 32'(err_count), ec);
  endtask

  task automatic drive(input bit v, input bit c, input logic [7:0] d);
    valid = v;
    clear = c;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit         v;
    bit         c;
    logic [7:0] d;
    bit         l;
    bit         e;
    logic [7:0] x;
    int         mc;
    int         ec;
  } vec_t;

  vec_t vt[$];

  initial begin
    rst_n = 1'b0;
    clear = 1'b0;
    valid = 1'b0;
    data  = 8'h00;

    //        v  c  data   lock err  exp    match err
    vt.push_back('{1, 0, 8'hAF, 1, 0, 8'hBC, 1,  0});
    vt.push_back('{1, 0, 8'hBC, 1, 0, 8'hE2, 2,  0});
    vt.push_back('{1, 0, 8'hE2, 1, 0, 8'h78, 3,  0});
    vt.push_back('{1, 0, 8'h78, 1, 0, 8'h1B, 4,  0});
    vt.push_back('{1, 0, 8'h1B, 1, 0, 8'h34, 5,  0});
    vt.push_back('{1, 0, 8'h34, 1, 0, 8'h5D, 6,  0});
    vt.push_back('{1, 0, 8'h5D, 1, 0, 8'hC6, 7,  0});
    vt.push_back('{1, 0, 8'hC6, 1, 0, 8'hAF, 8,  0});
    vt.push_back('{1, 0, 8'hAF, 1, 0, 8'hBC, 9,  0});
    vt.push_back('{1, 0, 8'hBC, 1, 0, 8'hE2, 10, 0});
    vt.push_back('{1, 0, 8'h00, 1, 1, 8'h78, 10, 1});
    vt.push_back('{1, 0, 8'h78, 1, 0, 8'h1B, 11, 1});
    vt.push_back('{1, 0, 8'h00, 1, 1, 8'h34, 11, 2});
    vt.push_back('{1, 0, 8'h00, 0, 1, 8'hAF, 11, 3});
    vt.push_back('{1, 0, 8'h12, 0, 0, 8'hAF, 11, 3});
    vt.push_back('{1, 0, 8'h34, 0, 0, 8'hAF, 11, 3});
    vt.push_back('{1, 0, 8'hAF, 1, 0, 8'hBC, 12, 3});
    vt.push_back('{0, 0, 8'h00, 1, 0, 8'hBC, 12, 3});
    vt.push_back('{0, 0, 8'hBC, 1, 0, 8'hBC, 12, 3});
    vt.push_back('{1, 0, 8'hBC, 1, 0, 8'hE2, 13, 3});
    vt.push_back('{1, 1, 8'hAF, 0, 0, 8'hAF, 0,  0});

    #12;
    check_all("reset", 0, 0, 8'hAF, 0, 0);
    rst_n = 1'b1;

    foreach (vt[i]) begin
      drive(vt[i].v, vt[i].c, vt[i].d);
      check_all($sformatf("vec%0d", i), vt[i].l, vt[i].e, vt[i].x, vt[i].mc, vt[i].ec);
    end

    // Gap of idle cycles while locked, then resume with the next sample.
    drive(1, 0, 8'hAF);
    drive(1, 0, 8'hBC);
    drive(1, 0, 8'hE2);
    for (int k = 0; k < 10; k++) begin
      drive(0, 0, 8'h78);
      check_all($sformatf("gap%0d", k), 1, 0, 8'h78, 3, 0);
    end
    drive(1, 0, 8'h78);
    check_all("resume", 1, 0, 8'h1B, 4, 0);

    // Asynchronous reset mid-sequence, then clear racing a valid AF.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 0, 0, 8'hAF, 0, 0);
    @(posedge clk);
    #1;
    check_all("rst_hold", 0, 0, 8'hAF, 0, 0);
    rst_n = 1'b1;
    drive(1, 1, 8'hAF);
    check_all("clear_wins", 0, 0, 8'hAF, 0, 0);
    drive(1, 0, 8'hAF);
    check_all("relock", 1, 0, 8'hBC, 1, 0);

    // Random traffic against the model.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      bit         v;
      bit         c;
      logic [7:0] d;
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) < 8) d = 8'(model_expected());
      else d = 8'($urandom);
      drive(v, c, d);
      model_step(v, c, d);
      check_all($sformatf("rnd%0d", n), m_locked, m_error, 8'(model_expected()), m_match,
                m_errc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
